// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t     : FSM encoding (IDLE / RUN / DONE)
//   NIBBLE_W    : width of one processed digit (4 bits)
//   MAX_NIBBLES : largest supported NIBBLES parameter
//   IDX_W       : width of the nibble index register, sized for MAX_NIBBLES
package nsa_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int MAX_NIBBLES = 8;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_fourbitadder.sv
// fourbitadder: combinational 4-bit ripple-carry adder built from full-adder
// equations.
//   a, b : 4-bit addends
//   cin  : carry-in
//   sum  : 4-bit result
//   cout : carry out of bit 3
module fourbitadder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W-bit unsigned operands (W = 4*NIBBLES) plus
// a carry-in one nibble per clock, using a single fourbitadder instance.
//
// Ports:
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, cin            : operands, captured on the accepting edge
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, cout            : registered result, held stable while in DONE
//   dbg_state            : current FSM state, for observation
//   ovf                  : signed overflow of the full sum, only present when
//                          NSA_OVERFLOW_EN is defined
//
// Handshake rule: a transfer happens on a rising edge where valid && ready are
// both 1; the producer keeps valid and data stable until that edge, and ready
// never depends combinationally on valid.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout,
    output state_t                      dbg_state
`ifdef NSA_OVERFLOW_EN
    ,
    output logic                        ovf
`endif
);

    localparam int                   W        = NIBBLE_W * NIBBLES;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic [W-1:0]         r_sum;
    logic                 r_carry;
    logic                 r_cout;
    logic [IDX_W-1:0]     r_idx;

    logic                 w_accept;
    logic                 w_last;
    logic [W-1:0]         w_a_sh;
    logic [W-1:0]         w_b_sh;
    logic [NIBBLE_W-1:0]  w_nib_a;
    logic [NIBBLE_W-1:0]  w_nib_b;
    logic [NIBBLE_W-1:0]  w_nib_sum;
    logic                 w_nib_cout;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Select the current nibble by shifting it down to bit 0.
    assign w_a_sh  = r_a >> {r_idx, 2'b00};
    assign w_b_sh  = r_b >> {r_idx, 2'b00};
    assign w_nib_a = w_a_sh[NIBBLE_W-1:0];
    assign w_nib_b = w_b_sh[NIBBLE_W-1:0];

    fourbitadder u_nibble_add (
        .a    (w_nib_a),
        .b    (w_nib_b),
        .cin  (r_carry),
        .sum  (w_nib_sum),
        .cout (w_nib_cout)
    );

    // Datapath. sum is zeroed on acceptance, so each RUN cycle can simply OR
    // its nibble into place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= r_sum | (W'(w_nib_sum) << {r_idx, 2'b00});
            r_carry <= w_nib_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_nib_cout;
            end
        end
    end

`ifdef NSA_OVERFLOW_EN
    logic r_ovf;
    logic w_c_into_msb;

    // Carry into the MSB recovered from the MSB's own sum bit.
    assign w_c_into_msb = w_nib_a[NIBBLE_W-1] ^ w_nib_b[NIBBLE_W-1] ^ w_nib_sum[NIBBLE_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_c_into_msb ^ w_nib_cout;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign dbg_state = r_state;

endmodule
